// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, branch/jump redirect, BUSYWAIT stall.
// Optional saturating stall counter enabled by defining PC_SEQ_STALL_COUNT_EN.
module pc_sequencer #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned          INC          = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                busywait,
    input  logic                jump,
    input  logic                branch,
    input  logic                branch_ne,
    input  logic                zero,
    input  logic [7:0]          offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                taken,
    output logic                stalled
`ifdef PC_SEQ_STALL_COUNT_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);

    typedef enum logic [1:0] {StBoot, StRun, StStall} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  taken_q, taken_d;
    logic                  stalled_q, stalled_d;
    logic [PC_WIDTH-1:0]   offset_ext;
    logic [PC_WIDTH-1:0]   target;
    logic [PC_WIDTH-1:0]   next_pc;
    logic                  redirect;

    assign pc_plus4   = pc_q + PC_WIDTH'(INC);
    assign offset_ext = {{(PC_WIDTH-8){offset[7]}}, offset};
    assign target     = pc_plus4 + (offset_ext << 2);
    assign redirect   = jump | (branch & zero) | (branch_ne & ~zero);
    assign next_pc    = redirect ? target : pc_plus4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        taken_d   = 1'b0;
        stalled_d = 1'b0;
        unique case (state_q)
            StBoot: begin
                // Hold the vector one cycle so the I-cache can fetch it.
                state_d = StRun;
            end
            StRun, StStall: begin
                if (busywait) begin
                    state_d   = StStall;
                    stalled_d = 1'b1;
                end else begin
                    state_d = StRun;
                    pc_d    = next_pc;
                    taken_d = redirect;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StBoot;
            pc_q      <= RESET_VECTOR;
            taken_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            taken_q   <= taken_d;
            stalled_q <= stalled_d;
        end
    end

    assign pc      = pc_q;
    assign taken   = taken_q;
    assign stalled = stalled_q;

`ifdef PC_SEQ_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    // The entry edge is spent in RUN, so only edges already in STALL count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StStall) && busywait && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
